// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with registered one-hot grant and hold-until-release.
// Define RR_ARB_TIMEOUT_EN to enforce the MAX_HOLD limit and drive the timeout pulse.
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 15,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Returns {found, index} of the first set bit scanning upward from p+1, modulo 8.
    function automatic logic [3:0] rr_search(input logic [7:0] r, input logic [2:0] p);
        logic [3:0] res;
        logic [2:0] cand;
        res = 4'b0000;
        for (int i = 8; i >= 1; i--) begin
            cand = p + i[2:0];
            if (r[cand]) begin
                res = {1'b1, cand};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    function automatic logic [7:0] dec3to8(input logic [2:0] idx);
        logic [7:0] oh;
        oh      = 8'h00;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    if ((MAX_HOLD < 1) || (MAX_HOLD > ((32'sd1 <<< HOLD_W) - 32'sd1))) begin : g_cfg_err
        $error("rr_arbiter_8: MAX_HOLD outside 1..2^HOLD_W-1");
    end

    state_t     state_q, state_d;
    logic [2:0] idx_q, idx_d;
    logic [2:0] ptr_q, ptr_d;
    logic       valid_q, valid_d;
    logic [7:0] gnt_q, gnt_d;
    logic [3:0] win_all_s;

    assign win_all_s = rr_search(req, ptr_q);

`ifdef RR_ARB_TIMEOUT_EN
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
    logic [3:0]        win_oth_s;

    // The grantee is masked so an expiry can only hand the grant to someone else.
    assign win_oth_s = rr_search(req & ~dec3to8(idx_q), ptr_q);
`endif

    // Next-state, grant selection and hold bookkeeping.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
`ifdef RR_ARB_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_all_s[3]) begin
                    state_d = ST_GRANT;
                    idx_d   = win_all_s[2:0];
                    ptr_d   = win_all_s[2:0];
                    valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = HOLD_ZERO;
`endif
                end else begin
                    valid_d = 1'b0;
                    idx_d   = 3'd0;
                end
            end
            ST_GRANT: begin
                if (req[idx_q]) begin
`ifdef RR_ARB_TIMEOUT_EN
                    if (hold_q == HOLD_LAST) begin
                        hold_d = HOLD_ZERO;
                        if (win_oth_s[3]) begin
                            idx_d     = win_oth_s[2:0];
                            ptr_d     = win_oth_s[2:0];
                            timeout_d = 1'b1;
                        end else begin
                            timeout_d = 1'b0;
                        end
                    end else begin
                        hold_d = hold_q + HOLD_ONE;
                    end
`else
                    valid_d = 1'b1;
`endif
                end else if (win_all_s[3]) begin
                    // Release with others waiting: hand over without an idle cycle.
                    idx_d   = win_all_s[2:0];
                    ptr_d   = win_all_s[2:0];
                    valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
                    hold_d  = HOLD_ZERO;
`endif
                end else begin
                    state_d = ST_IDLE;
                    valid_d = 1'b0;
                    idx_d   = 3'd0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // One-hot grant is decoded ahead of the register so the output stays glitch-free.
    always_comb begin
        if (valid_d) begin
            gnt_d = dec3to8(idx_d);
        end else begin
            gnt_d = 8'h00;
        end
    end

    // Arbiter state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            ptr_q   <= 3'd7;
            valid_q <= 1'b0;
            gnt_q   <= 8'h00;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            gnt_q   <= gnt_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Hold counter and timeout pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q    <= HOLD_ZERO;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8 (MAX_HOLD=4); timeout expectations
// follow RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter_8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'hFF;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    rr_arbiter_8 #(
        .MAX_HOLD(4),
        .HOLD_W  (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx),
        .gnt_valid(gnt_valid),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [7:0] g, input logic [2:0] idx,
                              input logic v, input logic to);
        check({tag, ".gnt"},       32'(gnt),       32'(g));
        check({tag, ".gnt_idx"},   32'(gnt_idx),   32'(idx));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        check({tag, ".timeout"},   32'(timeout),   32'(to));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_g;
        logic [2:0] exp_i;
        logic       exp_t;

        // Reset held across edges with every requester active.
        repeat (2) tick();
        check_outs("reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        check_outs("rst_release", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_outs("drop0", 8'h00, 3'd0, 1'b0, 1'b0);

        // Single request and release.
        req = 8'h04;
        tick();
        check_outs("single", 8'h04, 3'd2, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_outs("single_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Park the pointer on 0 so requester 1 wins next.
        req = 8'h01;
        tick();
        check_outs("prime0", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        // Back-to-back hand-over on release.
        req = 8'h0A;
        tick();
        check_outs("b2b_first", 8'h02, 3'd1, 1'b1, 1'b0);
        req = 8'h08;
        tick();
        check_outs("b2b_second", 8'h08, 3'd3, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_outs("b2b_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Sole requester keeps the grant well past the hold limit.
        req = 8'h10;
        tick();
        check_outs("sole_first", 8'h10, 3'd4, 1'b1, 1'b0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_outs("sole_hold", 8'h10, 3'd4, 1'b1, 1'b0);
        end
        req = 8'h00;
        tick();
        check_outs("sole_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Asynchronous reset between edges while index 5 holds the grant.
        req = 8'h20;
        tick();
        check_outs("pre_rst", 8'h20, 3'd5, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 check_outs("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
        #1 rst = 1'b0;
        req = 8'hFF;
        tick();
        check_outs("post_rst", 8'h01, 3'd0, 1'b1, 1'b0);
        req = 8'h00;
        tick();
        check_outs("post_rst_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        // Park the pointer on 7 so requester 0 wins the 8'h81 contest.
        req = 8'h80;
        tick();
        check_outs("prime7", 8'h80, 3'd7, 1'b1, 1'b0);
        req = 8'h00;
        tick();

        // Two continuous requesters: rotation on hold expiry, or none without it.
        req = 8'h81;
        for (int t = 0; t < 12; t++) begin
            tick();
`ifdef RR_ARB_TIMEOUT_EN
            exp_i = (((t / 4) % 2) == 1) ? 3'd7 : 3'd0;
            exp_t = (t > 0) && ((t % 4) == 0);
`else
            exp_i = 3'd0;
            exp_t = 1'b0;
`endif
            exp_g = (exp_i == 3'd7) ? 8'h80 : 8'h01;
            check_outs($sformatf("rot_t%0d", t), exp_g, exp_i, 1'b1, exp_t);
        end
        req = 8'h00;
        tick();
        check_outs("final_rel", 8'h00, 3'd0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
